// File: rtl/pulse_sched_pkg.sv
// Shared types and default widths for the timed pulse-command scheduler.
package pulse_sched_pkg;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefCmdWidth  = 79;
  localparam int unsigned DefTimeWidth = 32;
  localparam int unsigned DefFifoDepth = 8;
  localparam int unsigned DefMinGap    = 2;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StFire,
    StGap
  } state_e;

  // FIFO entry layout, most significant field first.
  typedef struct packed {
    logic [DefTimeWidth-1:0] trig_time;
    logic [DefDataWidth-1:0] reg_op;
    logic [DefCmdWidth-1:0]  cmd;
  } entry_t;

endpackage

// File: rtl/pulse_sched_fifo.sv
// Synchronous FIFO with flush; head is read straight from the storage array.
module pulse_sched_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [Width-1:0]         wdata_i,
  output logic [Width-1:0]         head_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  // Flush wins over both push and pop.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/pulse_sched.sv
// Timed issue controller: fires queued pulse commands when the time counter reaches them.
// Optional PULSE_SCHED_LATE_FLAG_EN adds late / late_sticky outputs for past-due issues.
module pulse_sched
  import pulse_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DefDataWidth,
  parameter int unsigned PULSE_CMD_WIDTH = DefCmdWidth,
  parameter int unsigned TIME_WIDTH      = DefTimeWidth,
  parameter int unsigned FIFO_DEPTH      = DefFifoDepth,
  parameter int unsigned MIN_GAP         = DefMinGap
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_valid,
  output logic                          push_ready,
  input  logic [PULSE_CMD_WIDTH-1:0]    push_cmd,
  input  logic [DATA_WIDTH-1:0]         push_reg,
  input  logic [TIME_WIDTH-1:0]         push_time,
  input  logic                          flush,
  input  logic                          time_rst,
  output logic [TIME_WIDTH-1:0]         time_now,
  output logic [PULSE_CMD_WIDTH-1:0]    pulse_cmd_out,
  output logic [DATA_WIDTH-1:0]         reg_out,
  output logic                          pulse_write_en,
  output logic                          cstrobe_out,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
`ifdef PULSE_SCHED_LATE_FLAG_EN
  ,
  output logic                          late,
  output logic                          late_sticky
`endif
);

  localparam int unsigned EntryW = TIME_WIDTH + DATA_WIDTH + PULSE_CMD_WIDTH;
  localparam int unsigned GapW   = (MIN_GAP > 2) ? $clog2(MIN_GAP - 1) : 1;

  state_e                     state_q, state_d;
  logic [GapW-1:0]            gap_q, gap_d;
  logic [TIME_WIDTH-1:0]      time_q;
  logic [PULSE_CMD_WIDTH-1:0] cmd_q, cmd_d;
  logic [DATA_WIDTH-1:0]      reg_q, reg_d;
  logic [EntryW-1:0]          head;
  logic [TIME_WIDTH-1:0]      head_time;
  logic                       fifo_full, fifo_empty, pop, eval, due;

  pulse_sched_fifo #(
    .Width (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (push_valid),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i ({push_time, push_reg, push_cmd}),
    .head_o  (head),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_time = head[EntryW-1 -: TIME_WIDTH];
  assign due       = !fifo_empty && (head_time <= time_q);

  always_ff @(posedge clk) begin
    if (reset || time_rst) time_q <= '0;
    else                   time_q <= time_q + TIME_WIDTH'(1);
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    cmd_d   = cmd_q;
    reg_d   = reg_q;
    pop     = 1'b0;
    eval    = 1'b0;
    unique case (state_q)
      StIdle: if (!fifo_empty) state_d = StWait;
      StWait: eval = 1'b1;
      StFire: begin
        if (MIN_GAP > 1) begin
          state_d = StGap;
          gap_d   = GapW'(MIN_GAP - 2);
        end else begin
          eval = 1'b1;
        end
      end
      StGap: begin
        // Last gap cycle doubles as a compare cycle so strobes land exactly MIN_GAP apart.
        if (gap_q == '0) eval = 1'b1;
        else             gap_d = gap_q - GapW'(1);
      end
      default: state_d = StIdle;
    endcase
    if (eval) begin
      if (fifo_empty) begin
        state_d = StIdle;
      end else if (due) begin
        state_d = StFire;
        pop     = 1'b1;
        cmd_d   = head[PULSE_CMD_WIDTH-1:0];
        reg_d   = head[PULSE_CMD_WIDTH +: DATA_WIDTH];
      end else begin
        state_d = StWait;
      end
    end
    if (flush) begin
      state_d = StIdle;
      pop     = 1'b0;
      cmd_d   = cmd_q;
      reg_d   = reg_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      gap_q   <= '0;
      cmd_q   <= '0;
      reg_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      cmd_q   <= cmd_d;
      reg_q   <= reg_d;
    end
  end

`ifdef PULSE_SCHED_LATE_FLAG_EN
  logic late_q, sticky_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      late_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      late_q <= pop && (head_time < time_q);
      if (flush)                             sticky_q <= 1'b0;
      else if (pop && (head_time < time_q))  sticky_q <= 1'b1;
    end
  end

  assign late        = late_q;
  assign late_sticky = sticky_q;
`endif

  assign push_ready     = !fifo_full;
  assign empty          = fifo_empty;
  assign time_now       = time_q;
  assign pulse_cmd_out  = cmd_q;
  assign reg_out        = reg_q;
  assign pulse_write_en = (state_q == StFire);
  assign cstrobe_out    = (state_q == StFire);

endmodule

// File: tb/tb_pulse_sched.sv
// Directed bench for pulse_sched: issue timing, gap spacing, full/flush/reset behaviour.
module tb_pulse_sched;

  logic        clk = 1'b0;
  logic        reset, push_valid, push_ready, flush, time_rst;
  logic [78:0] push_cmd, pulse_cmd_out;
  logic [31:0] push_reg, push_time, time_now, reg_out;
  logic        pulse_write_en, cstrobe_out, empty;
  logic [3:0]  count;
`ifdef PULSE_SCHED_LATE_FLAG_EN
  logic        late, late_sticky;
`endif

  int checks = 0;
  int errors = 0;
  int exp_t  = 0;

  pulse_sched dut (
    .clk            (clk),
    .reset          (reset),
    .push_valid     (push_valid),
    .push_ready     (push_ready),
    .push_cmd       (push_cmd),
    .push_reg       (push_reg),
    .push_time      (push_time),
    .flush          (flush),
    .time_rst       (time_rst),
    .time_now       (time_now),
    .pulse_cmd_out  (pulse_cmd_out),
    .reg_out        (reg_out),
    .pulse_write_en (pulse_write_en),
    .cstrobe_out    (cstrobe_out),
    .empty          (empty),
    .count          (count)
`ifdef PULSE_SCHED_LATE_FLAG_EN
    ,
    .late           (late),
    .late_sticky    (late_sticky)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [78:0] mk_cmd(input int id);
    logic [31:0] v;
    v = 32'hDEAD0000 + 32'(id);
    return {15'h5A5A, v, 32'h0000BEEF};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    exp_t++;
  endtask

  task automatic set_push(input int id, input logic [31:0] t);
    push_valid = 1'b1;
    push_cmd   = mk_cmd(id);
    push_reg   = 32'h1000 + 32'(id);
    push_time  = t;
  endtask

  // Ticks until a strobe is visible; at = -1 when the budget runs out.
  task automatic wait_strobe(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (pulse_write_en === 1'b1) begin
        at = exp_t;
        break;
      end
      tick();
    end
  endtask

  int          at;
  int          n;
  int          st_t [3];
  logic [78:0] st_c [3];
  logic        saw;
  int          t0;

  initial begin
    reset = 1'b1; push_valid = 1'b0; flush = 1'b0; time_rst = 1'b0;
    push_cmd = '0; push_reg = '0; push_time = '0;
    repeat (3) @(posedge clk);
    #1;
    exp_t = 0;
    chk("rst_time", time_now, 0);
    chk("rst_we", pulse_write_en, 0);
    chk("rst_strobe", cstrobe_out, 0);
    chk("rst_ready", push_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_cmd", pulse_cmd_out, 0);
    reset = 1'b0;
    tick();
    chk("time_inc", time_now, 1);

    // Single command, trigger 20, pushed at 5.
    while (exp_t < 5) tick();
    set_push(1, 32'd20);
    tick();
    push_valid = 1'b0;
    chk("one_count", count, 1);
    wait_strobe(40, at);
    chk("one_at", at, 21);
    chk("one_strobe", cstrobe_out, 1);
    chk("one_cmd", pulse_cmd_out, mk_cmd(1));
    chk("one_reg", reg_out, 32'h1001);
    tick();
    chk("one_we_low", pulse_write_en, 0);
    chk("one_cmd_hold", pulse_cmd_out, mk_cmd(1));

    // Three commands at the same time, spaced by the minimum gap.
    set_push(2, 32'd30); tick();
    set_push(3, 32'd30); tick();
    set_push(4, 32'd30); tick();
    push_valid = 1'b0;
    chk("three_count", count, 3);
    n = 0;
    for (int i = 0; i < 14; i++) begin
      if (pulse_write_en === 1'b1) begin
        if (n < 3) begin
          st_t[n] = exp_t;
          st_c[n] = pulse_cmd_out;
        end
        n++;
      end
      tick();
    end
    chk("three_n", n, 3);
    chk("three_t0", st_t[0], 31);
    chk("three_t1", st_t[1], 33);
    chk("three_t2", st_t[2], 35);
    chk("three_c0", st_c[0], mk_cmd(2));
    chk("three_c1", st_c[1], mk_cmd(3));
    chk("three_c2", st_c[2], mk_cmd(4));

    // Fill to full; first entry comes due and frees one slot.
    t0 = exp_t;
    for (int i = 0; i < 8; i++) begin
      set_push(20 + i, (i == 0) ? 32'(t0 + 15) : 32'hFFFF0000);
      tick();
    end
    chk("full_ready", push_ready, 0);
    chk("full_count", count, 8);
    set_push(99, 32'd0);
    while (exp_t < t0 + 15) tick();
    chk("full_ready_pop", push_ready, 0);
    chk("full_we_pre", pulse_write_en, 0);
    tick();
    push_valid = 1'b0;
    chk("full_we", pulse_write_en, 1);
    chk("full_cmd", pulse_cmd_out, mk_cmd(20));
    chk("full_ready_after", push_ready, 1);
    chk("full_count_after", count, 7);
    tick();
    chk("ninth_dropped", count, 7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_full_empty", empty, 1);
    chk("flush_full_count", count, 0);

    // Flush a queue of three, then flush with a simultaneous push.
    for (int i = 0; i < 3; i++) begin
      set_push(60 + i, 32'(exp_t + 20));
      tick();
    end
    push_valid = 1'b0;
    chk("q3_count", count, 3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("q3_flush_empty", empty, 1);
    chk("q3_flush_count", count, 0);
    saw = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (pulse_write_en === 1'b1) saw = 1'b1;
      tick();
    end
    chk("q3_no_strobe", saw, 0);
    set_push(70, 32'hFFFF0000);
    tick();
    set_push(71, 32'hFFFF0000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    push_valid = 1'b0;
    chk("flush_push_count", count, 0);
    chk("flush_push_empty", empty, 1);

    // Counter reset leaves the FIFO alone.
    time_rst = 1'b1;
    tick();
    time_rst = 1'b0;
    exp_t = 0;
    chk("trst_zero", time_now, 0);
    tick();
    chk("trst_one", time_now, 1);

    // Past-due command.
    while (exp_t < 50) tick();
    set_push(40, 32'd3);
    tick();
    push_valid = 1'b0;
    wait_strobe(10, at);
    chk("late_at", at, 53);
    chk("late_cmd", pulse_cmd_out, mk_cmd(40));
`ifdef PULSE_SCHED_LATE_FLAG_EN
    chk("late_flag", late, 1);
    chk("late_sticky", late_sticky, 1);
`endif
    tick();
`ifdef PULSE_SCHED_LATE_FLAG_EN
    chk("late_flag_drop", late, 0);
    chk("late_sticky_hold", late_sticky, 1);
`endif

    // Reset while a fire is on the outputs.
    set_push(50, 32'(exp_t + 5));
    tick();
    push_valid = 1'b0;
    wait_strobe(20, at);
    chk("rf_at", at, 60);
    chk("rf_cmd", pulse_cmd_out, mk_cmd(50));
    reset = 1'b1;
    tick();
    chk("rf_we", pulse_write_en, 0);
    chk("rf_count", count, 0);
    chk("rf_time", time_now, 0);
    chk("rf_cmd_zero", pulse_cmd_out, 0);
    chk("rf_reg_zero", reg_out, 0);
`ifdef PULSE_SCHED_LATE_FLAG_EN
    chk("rf_sticky", late_sticky, 0);
`endif
    reset = 1'b0;
    exp_t = 0;
    tick();
    chk("rf_time_restart", time_now, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
